// File: rtl/tx_dac_output_stage_if.sv
// tx_dac_output_stage_if: sample and control bundle between the TX DSP core,
// the DAC output stage and the RF-DAC.
//   tx_enable       level request for unmuted output
//   pattern_select  0 pass-through, 1 DC, 2 ramp, 3 zero
//   dc_level        signed DC value used by pattern 1
//   tx_data         NUMBER_OF_LINE signed 16-bit samples from the DSP core
//   dac_data        NUMBER_OF_LINE signed 16-bit samples to the RF-DAC
//   ramp_state      0 IDLE, 1 RAMP_UP, 2 ACTIVE, 3 RAMP_DOWN
//   ramp_done       one-cycle pulse when a gain ramp completes
//   dac_muted       high when the gain behind the current dac_data was 0
// master: the side that drives the samples and controls (DSP core / bench).
// slave : the output stage itself.
interface tx_dac_output_stage_if #(
  parameter int NUMBER_OF_LINE = 8
);
  logic                          tx_enable;
  logic [1:0]                    pattern_select;
  logic [15:0]                   dc_level;
  logic [16*NUMBER_OF_LINE-1:0]  tx_data;
  logic [16*NUMBER_OF_LINE-1:0]  dac_data;
  logic [1:0]                    ramp_state;
  logic                          ramp_done;
  logic                          dac_muted;

  modport master (
    output tx_enable, pattern_select, dc_level, tx_data,
    input  dac_data, ramp_state, ramp_done, dac_muted
  );

  modport slave (
    input  tx_enable, pattern_select, dc_level, tx_data,
    output dac_data, ramp_state, ramp_done, dac_muted
  );
endinterface

// File: rtl/tx_dac_output_stage.sv
// tx_dac_output_stage: final TX stage before the RF-DAC. Selects a source
// (DSP samples or a test pattern), scales every lane by a soft mute/unmute
// gain ramp, then rounds and saturates into a 3-clock pipeline.
// Ports:
//   clock  sample-rate fabric clock, rising edge
//   reset  synchronous, active-high
//   bus    tx_dac_output_stage_if.slave (controls, tx_data in, dac_data and
//          status out)
// Gain is Q1.15 unsigned: 32768 means unity, so the ramp length is
// 32768 / GAIN_STEP clocks.
module tx_dac_output_stage #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int GAIN_STEP      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  tx_dac_output_stage_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 17;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [COEF_W-1:0] UNITY = COEF_W'(32768);
  localparam logic [COEF_W-1:0] STEP  = COEF_W'(GAIN_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Add half an LSB of the output scale and drop the 15 fraction bits.
  function automatic logic signed [SUM_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p
  );
    logic signed [SUM_W-1:0] r;
    r = SUM_W'(p) + SUM_W'(16384);
    return r >>> 15;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(
    input logic signed [SUM_W-1:0] v
  );
    if (v > SUM_W'(32767))
      return 16'sh7fff;
    else if (v < -SUM_W'(32768))
      return 16'sh8000;
    else
      return v[DATA_W-1:0];
  endfunction

  // Gain ramp control
  state_t            state;
  state_t            state_next;
  logic [15:0]       gain;
  logic [15:0]       gain_next;
  logic              done_next;
  logic              ramp_done;
  logic [COEF_W-1:0] gain_up;

  assign gain_up = {1'b0, gain} + STEP;

  always_comb begin
    state_next = state;
    gain_next  = gain;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_enable)
          state_next = RAMP_UP;
      end
      RAMP_UP: begin
        // A reversal holds the gain for this cycle and continues from it.
        if (!bus.tx_enable) begin
          state_next = RAMP_DOWN;
        end else if (gain_up >= UNITY) begin
          gain_next  = 16'h8000;
          state_next = ACTIVE;
          done_next  = 1'b1;
        end else begin
          gain_next = gain_up[15:0];
        end
      end
      ACTIVE: begin
        if (!bus.tx_enable)
          state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (bus.tx_enable) begin
          state_next = RAMP_UP;
        end else if ({1'b0, gain} <= STEP) begin
          gain_next  = 16'h0000;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          gain_next = gain - STEP[15:0];
        end
      end
      default: begin
        state_next = IDLE;
        gain_next  = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gain      <= 16'h0000;
      ramp_done <= 1'b0;
    end else begin
      state     <= state_next;
      gain      <= gain_next;
      ramp_done <= done_next;
    end
  end

  // Ramp test pattern: lanes carry consecutive values across cycles.
  logic [15:0] base;

  always_ff @(posedge clock) begin
    if (reset)
      base <= 16'h0000;
    else
      base <= base + 16'(NUMBER_OF_LINE);
  end

  logic signed [DATA_W-1:0] lane_mux [NUMBER_OF_LINE];

  always_comb begin
    for (int k = 0; k < NUMBER_OF_LINE; k++) begin
      lane_mux[k] = '0;
      case (bus.pattern_select)
        2'd0:    lane_mux[k] = bus.tx_data[16*k +: 16];
        2'd1:    lane_mux[k] = bus.dc_level;
        2'd2:    lane_mux[k] = base + 16'(k);
        default: lane_mux[k] = '0;
      endcase
    end
  end

  logic signed [DATA_W-1:0] lane_p0 [NUMBER_OF_LINE];
  logic [15:0]              gain_p0;
  logic                     mute_p0;
  logic signed [PROD_W-1:0] prod_p1 [NUMBER_OF_LINE];
  logic                     mute_p1;
  logic [16*NUMBER_OF_LINE-1:0] dac_p2;
  logic                     mute_p2;

  // Stage 1: source select, gain captured with the samples it will scale
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUMBER_OF_LINE; k++)
        lane_p0[k] <= '0;
      gain_p0 <= 16'h0000;
      mute_p0 <= 1'b1;
    end else begin
      for (int k = 0; k < NUMBER_OF_LINE; k++)
        lane_p0[k] <= lane_mux[k];
      gain_p0 <= gain;
      mute_p0 <= (gain == 16'h0000);
    end
  end

  // Stage 2: signed 16 x 17 multiply; gain is zero-extended so 32768 stays positive
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUMBER_OF_LINE; k++)
        prod_p1[k] <= '0;
      mute_p1 <= 1'b1;
    end else begin
      for (int k = 0; k < NUMBER_OF_LINE; k++)
        prod_p1[k] <= PROD_W'(lane_p0[k]) * PROD_W'($signed({1'b0, gain_p0}));
      mute_p1 <= mute_p0;
    end
  end

  // Stage 3: round half up, shift out the gain fraction, saturate
  always_ff @(posedge clock) begin
    if (reset) begin
      dac_p2  <= '0;
      mute_p2 <= 1'b1;
    end else begin
      for (int k = 0; k < NUMBER_OF_LINE; k++)
        dac_p2[16*k +: 16] <= saturate(round_shift(prod_p1[k]));
      mute_p2 <= mute_p1;
    end
  end

  assign bus.dac_data   = dac_p2;
  assign bus.dac_muted  = mute_p2;
  assign bus.ramp_state = state;
  assign bus.ramp_done  = ramp_done;

endmodule

// File: tb/tb_tx_dac_output_stage.sv
// tb_tx_dac_output_stage: randomized bench for tx_dac_output_stage with a
// behavioural reference model (integer gain/base, queue of expected outputs).
module tb_tx_dac_output_stage;
  localparam int NL = 8;
  localparam int GS = 32;
  localparam int W  = 16 * NL;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_dac_output_stage_if #(.NUMBER_OF_LINE(NL)) bus ();

  tx_dac_output_stage #(.NUMBER_OF_LINE(NL), .GAIN_STEP(GS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int           m_state;
  int           m_gain;
  int           m_base;
  logic [W-1:0] pipe_q [$];
  logic         mute_q [$];
  logic [W-1:0] exp_dac;
  logic         exp_mute;
  logic         exp_done;
  int           done_seen;
  int           up_seen;

  // Real-number meaning: round(s * g / 32768) with halves toward +inf, clamped.
  function automatic int scale(int s, int g);
    longint p;
    longint q;
    p = longint'(s) * g + 16384;
    if (p >= 0) q = p / 32768;
    else        q = -((-p + 32767) / 32768);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int source(int k);
    logic [15:0] v;
    case (bus.pattern_select)
      2'd0:    v = bus.tx_data[16*k +: 16];
      2'd1:    v = bus.dc_level;
      2'd2:    v = 16'((m_base + k) % 65536);
      default: v = 16'h0000;
    endcase
    return int'($signed(v));
  endfunction

  task automatic rand_data();
    for (int k = 0; k < NL; k++)
      bus.tx_data[16*k +: 16] = 16'($urandom);
  endtask

  task automatic tick();
    logic [W-1:0] cap;
    for (int k = 0; k < NL; k++)
      cap[16*k +: 16] = 16'(scale(source(k), m_gain));
    exp_done = 1'b0;
    if (reset) begin
      m_state  = 0;
      m_gain   = 0;
      m_base   = 0;
      pipe_q   = {W'(0), W'(0)};
      mute_q   = {1'b1, 1'b1};
      exp_dac  = '0;
      exp_mute = 1'b1;
    end else begin
      exp_dac  = pipe_q.pop_front();
      exp_mute = mute_q.pop_front();
      pipe_q.push_back(cap);
      mute_q.push_back(m_gain == 0);
      m_base = (m_base + NL) % 65536;
      case (m_state)
        0: if (bus.tx_enable) m_state = 1;
        1: begin
          if (!bus.tx_enable) m_state = 3;
          else begin
            m_gain = (m_gain + GS > 32768) ? 32768 : m_gain + GS;
            if (m_gain == 32768) begin m_state = 2; exp_done = 1'b1; end
          end
        end
        2: if (!bus.tx_enable) m_state = 3;
        default: begin
          if (bus.tx_enable) m_state = 1;
          else begin
            m_gain = (m_gain - GS < 0) ? 0 : m_gain - GS;
            if (m_gain == 0) begin m_state = 0; exp_done = 1'b1; end
          end
        end
      endcase
    end
    @(posedge clock);
    #1;
    check("dac_data", bus.dac_data, exp_dac);
    check("ramp_state", W'(bus.ramp_state), W'(m_state));
    check("ramp_done", W'(bus.ramp_done), W'(exp_done));
    check("dac_muted", W'(bus.dac_muted), W'(exp_mute));
    if (bus.ramp_done) done_seen++;
    if (bus.ramp_state == 2'd1) up_seen++;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) rand_data();
      tick();
    end
  endtask

  initial begin
    logic [W-1:0] v;
    int           vals [NL];
    int           n;

    reset              = 1'b1;
    bus.tx_enable      = 1'b0;
    bus.pattern_select = 2'd0;
    bus.dc_level       = 16'h0000;
    bus.tx_data        = '0;
    run(2, 1'b0);
    check("reset_dac", bus.dac_data, W'(0));
    check("reset_muted", W'(bus.dac_muted), W'(1));

    // Full ramp up on a DC pattern: output tracks gain/2
    reset = 1'b0;
    bus.tx_enable = 1'b1; bus.pattern_select = 2'd1; bus.dc_level = 16'sd16384;
    done_seen = 0; up_seen = 0;
    run(1030, 1'b1);
    check("up_cycles", W'(up_seen), W'(1024));
    check("up_done_count", W'(done_seen), W'(1));
    check("up_active", W'(bus.ramp_state), W'(2));
    check("up_dc_lane0", W'(bus.dac_data[15:0]), W'(16384));

    // Unity gain is bit-exact at the extremes
    vals = '{32767, -32768, 1, -1, 0, 100, -100, 12345};
    for (int k = 0; k < NL; k++) v[16*k +: 16] = 16'(vals[k]);
    bus.pattern_select = 2'd0; bus.tx_data = v;
    tick();
    run(2, 1'b1);
    check("unity_exact", bus.dac_data, v);

    // Full ramp down
    bus.tx_enable = 1'b0; done_seen = 0;
    run(1030, 1'b1);
    check("down_done_count", W'(done_seen), W'(1));
    check("down_idle", W'(bus.ramp_state), W'(0));
    check("down_dac_zero", bus.dac_data, W'(0));
    check("down_muted", W'(bus.dac_muted), W'(1));

    // Reversal mid ramp-up and back: no ramp_done pulses
    bus.tx_enable = 1'b1; bus.pattern_select = 2'd1; done_seen = 0;
    run(101, 1'b1);
    bus.tx_enable = 1'b0;
    run(10, 1'b1);
    bus.tx_enable = 1'b1;
    run(20, 1'b1);
    check("reversal_no_done", W'(done_seen), W'(0));

    // Round half up at gain 16384
    n = 0;
    while (m_gain != 16384 && n < 2000) begin tick(); n++; end
    check("reach_half_gain", W'(m_gain == 16384), W'(1));
    bus.pattern_select = 2'd0;
    for (int k = 0; k < NL; k++) bus.tx_data[16*k +: 16] = (k % 2 == 0) ? -16'sd3 : 16'sd3;
    tick();
    run(2, 1'b1);
    check("round_neg3", W'(bus.dac_data[15:0]), W'(16'hffff));
    check("round_pos3", W'(bus.dac_data[31:16]), W'(2));

    // Reset in the middle of a ramp down, then restart with tx_enable high
    n = 0;
    while (m_state != 2 && n < 2000) begin rand_data(); tick(); n++; end
    check("reach_active", W'(m_state), W'(2));
    bus.tx_enable = 1'b0;
    run(300, 1'b1);
    reset = 1'b1;
    tick();
    check("midreset_dac", bus.dac_data, W'(0));
    check("midreset_idle", W'(bus.ramp_state), W'(0));
    reset = 1'b0; bus.tx_enable = 1'b1;
    tick();
    check("restart_up", W'(bus.ramp_state), W'(1));

    // Ramp pattern through a base wrap
    reset = 1'b1; tick(); reset = 1'b0;
    bus.pattern_select = 2'd2;
    run(9000, 1'b0);

    // Random phase: enable toggles, pattern changes, occasional reset
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      if ($urandom_range(0, 199) == 0) bus.tx_enable = ~bus.tx_enable;
      if ($urandom_range(0, 49) == 0) bus.pattern_select = 2'($urandom);
      if ($urandom_range(0, 49) == 0) bus.dc_level = 16'($urandom);
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
